// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM encoding and the
// read-data pattern returned when a server transaction is aborted.
package bus_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Wide enough for any practical DATA_WIDTH; users slice the low bits.
  localparam logic [63:0] TIMEOUT_DATA = '1;

endpackage

// File: rtl/bus_arbiter_if.sv
// Client and server side signals of the bus arbiter. The arbiter uses the
// master modport (it masters the server); the environment uses slave.
interface bus_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4
);
  localparam int ID_W = $clog2(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0]            rq;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] address;
  logic [NUM_CLIENTS-1:0]            wr_ni;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] dataW;
  logic [NUM_CLIENTS-1:0]            ack;
  logic [DATA_WIDTH-1:0]             dataR;
  logic                              srv_rq;
  logic [ADDR_WIDTH-1:0]             srv_address;
  logic                              srv_wr_ni;
  logic [DATA_WIDTH-1:0]             srv_dataW;
  logic                              srv_ack;
  logic [DATA_WIDTH-1:0]             srv_dataR;
  logic [ID_W-1:0]                   grant_id;
  logic                              timeout_err;

  modport master (
    input  rq, address, wr_ni, dataW, srv_ack, srv_dataR,
    output ack, dataR, srv_rq, srv_address, srv_wr_ni, srv_dataW, grant_id, timeout_err
  );

  modport slave (
    output rq, address, wr_ni, dataW, srv_ack, srv_dataR,
    input  ack, dataR, srv_rq, srv_address, srv_wr_ni, srv_dataW, grant_id, timeout_err
  );

endinterface

// File: rtl/bus_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr,
// wrapping, built as rotate / priority-encode / un-rotate.
module bus_rr_picker #(
  parameter int NUM_CLIENTS = 4,
  parameter int ID_W        = 2
) (
  input  logic [NUM_CLIENTS-1:0] eligible,
  input  logic [ID_W-1:0]        rr_ptr,
  output logic                   valid,
  output logic [ID_W-1:0]        winner
);

  localparam logic [ID_W:0] N_EXT = (ID_W+1)'(NUM_CLIENTS);

  logic [NUM_CLIENTS-1:0] rotated;
  logic [ID_W-1:0]        idx;
  logic [ID_W:0]          sum;

  always_comb begin
    rotated = NUM_CLIENTS'({eligible, eligible} >> rr_ptr);
    idx = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        idx = ID_W'(i);
      end
    end
    valid = |rotated;
    sum = {1'b0, idx} + {1'b0, rr_ptr};
    if (sum >= N_EXT) begin
      winner = ID_W'(sum - N_EXT);
    end else begin
      winner = sum[ID_W-1:0];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter forwarding one client transaction at a time to a server.
// Optional server-ack timeout is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic         clk,
  input logic         reset,
  bus_arbiter_if.master bus
);

  localparam int ID_W = $clog2(NUM_CLIENTS);

  logic [1:0]             state;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        grant_id;
  logic [ID_W-1:0]        pick_id;
  logic                   pick_valid;
  logic [NUM_CLIENTS-1:0] ack;
  logic [NUM_CLIENTS-1:0] ack_q;
  logic [NUM_CLIENTS-1:0] eligible;
  logic [DATA_WIDTH-1:0]  data_r;
  logic [DATA_WIDTH-1:0]  srv_data_w;
  logic [ADDR_WIDTH-1:0]  srv_address;
  logic                   srv_rq;
  logic                   srv_wr_ni;
  logic                   timeout_err;

  // A client acked last cycle may still show a stale rq, so it sits out one cycle.
  assign eligible = bus.rq & ~ack_q;

  bus_rr_picker #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .ID_W       (ID_W)
  ) picker (
    .eligible(eligible),
    .rr_ptr  (rr_ptr),
    .valid   (pick_valid),
    .winner  (pick_id)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] req_cnt;
  logic             limit_hit;

  assign limit_hit = (req_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Held at zero outside REQ, so it starts from zero on every REQ entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_cnt <= '0;
    end else if (state != ST_REQ) begin
      req_cnt <= '0;
    end else if (!limit_hit) begin
      req_cnt <= req_cnt + 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      ack         <= '0;
      ack_q       <= '0;
      data_r      <= '0;
      srv_rq      <= 1'b0;
      srv_address <= '0;
      srv_wr_ni   <= 1'b0;
      srv_data_w  <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      ack_q <= ack;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            srv_address <= bus.address[pick_id*ADDR_WIDTH +: ADDR_WIDTH];
            srv_wr_ni   <= bus.wr_ni[pick_id];
            srv_data_w  <= bus.dataW[pick_id*DATA_WIDTH +: DATA_WIDTH];
            grant_id    <= pick_id;
            srv_rq      <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A server ack on the limit cycle takes priority over the abort.
          if (bus.srv_ack) begin
            data_r <= bus.srv_dataR;
            srv_rq <= 1'b0;
            ack    <= NUM_CLIENTS'(1) << grant_id;
            state  <= ST_ACK;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (limit_hit) begin
            data_r      <= TIMEOUT_DATA[DATA_WIDTH-1:0];
            srv_rq      <= 1'b0;
            ack         <= NUM_CLIENTS'(1) << grant_id;
            timeout_err <= 1'b1;
            state       <= ST_ACK;
          end
`endif
        end
        ST_ACK: begin
          ack <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
          timeout_err <= 1'b0;
`endif
          rr_ptr <= (grant_id == ID_W'(NUM_CLIENTS - 1)) ? '0 : grant_id + 1'b1;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack         = ack;
  assign bus.dataR       = data_r;
  assign bus.srv_rq      = srv_rq;
  assign bus.srv_address = srv_address;
  assign bus.srv_wr_ni   = srv_wr_ni;
  assign bus.srv_dataW   = srv_data_w;
  assign bus.grant_id    = grant_id;
  assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a table of single transactions with
// hand-computed grants, plus sequences for hold, reset abort and server stall.
module tb_bus_arbiter;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int AW = 4;

  typedef struct {
    logic [3:0]  rq;
    logic [15:0] addr;
    logic [3:0]  wr_ni;
    logic [31:0] dataw;
    logic [7:0]  srv_dr;
    int          ack_delay;
    logic [1:0]  exp_grant;
    int          exp_lat;
    logic [3:0]  exp_addr;
    logic        exp_wr_ni;
    logic [7:0]  exp_dataw;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_CLIENTS(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bus_arbiter #(
    .NUM_CLIENTS   (NC),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    bus.rq = '0;
    bus.address = '0;
    bus.wr_ni = '0;
    bus.dataW = '0;
    bus.srv_ack = 1'b0;
    bus.srv_dataR = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; called at posedge+1 with the arbiter idle.
  task automatic apply_stimulus(input vec_t v, input string tag, input bit hold);
    int lat;
    logic [3:0] exp_ack;
    bus.rq = v.rq;
    bus.address = v.addr;
    bus.wr_ni = v.wr_ni;
    bus.dataW = v.dataw;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.srv_rq) begin
        lat = k;
        break;
      end
    end
    check_output({tag, " latency"}, lat, v.exp_lat);
    if (lat == 0) return;
    check_output({tag, " grant_id"}, bus.grant_id, v.exp_grant);
    check_output({tag, " srv_address"}, bus.srv_address, v.exp_addr);
    check_output({tag, " srv_wr_ni"}, bus.srv_wr_ni, v.exp_wr_ni);
    check_output({tag, " srv_dataW"}, bus.srv_dataW, v.exp_dataw);
    check_output({tag, " ack idle in REQ"}, bus.ack, 4'b0000);
    repeat (v.ack_delay) begin
      @(posedge clk);
      #1;
    end
    bus.srv_ack = 1'b1;
    bus.srv_dataR = v.srv_dr;
    @(posedge clk);
    #1;
    bus.srv_ack = 1'b0;
    bus.srv_dataR = 8'h00;
    exp_ack = 4'b0001 << v.exp_grant;
    check_output({tag, " ack"}, bus.ack, exp_ack);
    check_output({tag, " dataR"}, bus.dataR, v.srv_dr);
    check_output({tag, " srv_rq drop"}, bus.srv_rq, 1'b0);
    if (!hold) bus.rq = '0;
    @(posedge clk);
    #1;
    check_output({tag, " ack one cycle"}, bus.ack, 4'b0000);
    check_output({tag, " dataR hold"}, bus.dataR, v.srv_dr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[10];
    vec_t v;
    logic [3:0] t2_addr[5];
    logic       t2_wr[5];
    logic [7:0] t2_dw[5];
    int         bad;

    vecs[0] = '{4'b0001, 16'h9375, 4'b0001, 32'h3C664210, 8'hA5, 0, 2'd0, 1, 4'h5, 1'b1, 8'h10};
    vecs[1] = '{4'b0011, 16'h9375, 4'b0001, 32'h3C664210, 8'h11, 0, 2'd1, 1, 4'h7, 1'b0, 8'h42};
    vecs[2] = '{4'b0011, 16'h1234, 4'b1110, 32'hDDCCBBAA, 8'h22, 0, 2'd0, 1, 4'h4, 1'b0, 8'hAA};
    vecs[3] = '{4'b0011, 16'h1234, 4'b1110, 32'hDDCCBBAA, 8'h33, 0, 2'd1, 1, 4'h3, 1'b1, 8'hBB};
    vecs[4] = '{4'b0010, 16'h1234, 4'b1110, 32'hDDCCBBAA, 8'h44, 0, 2'd1, 2, 4'h3, 1'b1, 8'hBB};
    vecs[5] = '{4'b1100, 16'hFEDC, 4'b0100, 32'h01020304, 8'h55, 0, 2'd2, 1, 4'hE, 1'b1, 8'h02};
    vecs[6] = '{4'b1101, 16'hFEDC, 4'b0100, 32'h01020304, 8'h66, 0, 2'd3, 1, 4'hF, 1'b0, 8'h01};
    vecs[7] = '{4'b1110, 16'hFEDC, 4'b0100, 32'h01020304, 8'h77, 0, 2'd1, 1, 4'hD, 1'b0, 8'h03};
    vecs[8] = '{4'b1000, 16'hFEDC, 4'b0100, 32'h01020304, 8'h88, 0, 2'd3, 1, 4'hF, 1'b0, 8'h01};
    vecs[9] = '{4'b0110, 16'hFEDC, 4'b0100, 32'h01020304, 8'h99, 0, 2'd1, 1, 4'hD, 1'b0, 8'h03};

    bus.rq = '0;
    bus.address = '0;
    bus.wr_ni = '0;
    bus.dataW = '0;
    bus.srv_ack = 1'b0;
    bus.srv_dataR = '0;
    reset = 1'b1;
    #2;
    check_output("reset srv_rq", bus.srv_rq, 1'b0);
    check_output("reset ack", bus.ack, 4'b0000);
    check_output("reset dataR", bus.dataR, 8'h00);
    check_output("reset grant_id", bus.grant_id, 2'd0);
    check_output("reset timeout_err", bus.timeout_err, 1'b0);
    do_reset();
    check_output("idle srv_rq", bus.srv_rq, 1'b0);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i), 1'b0);
    end

    // Held rq=1111: strict rotation 0,1,2,3,0.
    do_reset();
    t2_addr = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h4};
    t2_wr   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    t2_dw   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA};
    for (int i = 0; i < 5; i++) begin
      v = '{4'b1111, 16'h1234, 4'b1110, 32'hDDCCBBAA, 8'(8'h20 + i), 1,
            2'(i % 4), 1, t2_addr[i], t2_wr[i], t2_dw[i]};
      apply_stimulus(v, $sformatf("hold%0d", i), 1'b1);
    end
    bus.rq = '0;

    // Client 3 write; client inputs change while the transaction is in REQ.
    do_reset();
    bus.rq = 4'b1000;
    bus.address = 16'h9000;
    bus.wr_ni = 4'b0000;
    bus.dataW = 32'h3C000000;
    @(posedge clk);
    #1;
    check_output("latch srv_rq", bus.srv_rq, 1'b1);
    check_output("latch grant_id", bus.grant_id, 2'd3);
    bus.address = 16'h2000;
    bus.dataW = 32'h00000000;
    bus.wr_ni = 4'b1000;
    bus.rq = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("latch srv_address c%0d", c), bus.srv_address, 4'h9);
      check_output($sformatf("latch srv_dataW c%0d", c), bus.srv_dataW, 8'h3C);
      check_output($sformatf("latch srv_wr_ni c%0d", c), bus.srv_wr_ni, 1'b0);
      check_output($sformatf("latch srv_rq c%0d", c), bus.srv_rq, 1'b1);
    end
    bus.srv_ack = 1'b1;
    bus.srv_dataR = 8'h5A;
    @(posedge clk);
    #1;
    bus.srv_ack = 1'b0;
    check_output("latch ack", bus.ack, 4'b1000);
    check_output("latch dataR", bus.dataR, 8'h5A);
    @(posedge clk);
    #1;
    check_output("latch ack drop", bus.ack, 4'b0000);

    // Async reset in REQ, then arbitration restarts from client 0.
    do_reset();
    v = '{4'b0010, 16'h0800, 4'b0000, 32'h00660000, 8'hC1, 0, 2'd1, 1, 4'h0, 1'b0, 8'h00};
    apply_stimulus(v, "pre-reset", 1'b0);
    bus.rq = 4'b0100;
    @(posedge clk);
    #1;
    check_output("abort srv_rq", bus.srv_rq, 1'b1);
    check_output("abort grant_id", bus.grant_id, 2'd2);
    bus.rq = 4'b0000;
    #2 reset = 1'b1;
    #1;
    check_output("async srv_rq", bus.srv_rq, 1'b0);
    check_output("async grant_id", bus.grant_id, 2'd0);
    check_output("async srv_address", bus.srv_address, 4'h0);
    check_output("async srv_dataW", bus.srv_dataW, 8'h00);
    check_output("async dataR", bus.dataR, 8'h00);
    check_output("async ack", bus.ack, 4'b0000);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    check_output("post-reset ack", bus.ack, 4'b0000);
    v = '{4'b0110, 16'h4321, 4'b1010, 32'h44332211, 8'hD1, 0, 2'd1, 1, 4'h2, 1'b1, 8'h22};
    apply_stimulus(v, "restart", 1'b0);
    v = '{4'b1000, 16'h4321, 4'b1010, 32'h44332211, 8'hD2, 0, 2'd3, 1, 4'h4, 1'b1, 8'h44};
    apply_stimulus(v, "client3", 1'b0);
    v = '{4'b0011, 16'h4321, 4'b1010, 32'h44332211, 8'hD3, 0, 2'd0, 1, 4'h1, 1'b0, 8'h11};
    apply_stimulus(v, "wrap", 1'b0);

    // Server never acks.
    do_reset();
    bus.rq = 4'b0001;
    bus.address = 16'h000B;
    bus.wr_ni = 4'b0001;
    bus.dataW = 32'h000000E7;
    @(posedge clk);
    #1;
    check_output("stall srv_rq", bus.srv_rq, 1'b1);
    bus.rq = 4'b0000;
    bad = 0;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (bus.ack !== 4'b0000 || bus.timeout_err !== 1'b0 || bus.srv_rq !== 1'b1) bad++;
    end
    check_output("stall no early abort", bad, 0);
    @(posedge clk);
    #1;
    check_output("timeout ack", bus.ack, 4'b0001);
    check_output("timeout_err pulse", bus.timeout_err, 1'b1);
    check_output("timeout dataR", bus.dataR, 8'hFF);
    check_output("timeout srv_rq", bus.srv_rq, 1'b0);
    @(posedge clk);
    #1;
    check_output("timeout ack drop", bus.ack, 4'b0000);
    check_output("timeout_err drop", bus.timeout_err, 1'b0);
`else
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (bus.ack !== 4'b0000 || bus.timeout_err !== 1'b0 || bus.srv_rq !== 1'b1) bad++;
    end
    check_output("stall waits 100 cycles", bad, 0);
`endif
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
